// File: rtl/framebuffer_scanout_if.sv
// Bus bundle between the framebuffer scan-out block and its neighbours:
// the VGA timing stage (pixel coordinates in, colour out) and the game
// logic (pixel writes, clear engine, buffer swap).
// The slave modport is the framebuffer side; master is the driving side.

interface framebuffer_scanout_if;
  // Scan-out side
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [3:0]  out_r;
  logic [3:0]  out_g;
  logic [3:0]  out_b;

  // Pixel write port
  logic        wr_en;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [11:0] wr_data;
  logic        wr_ready;

  // Clear engine
  logic        clear_req;
  logic [11:0] clear_color;
  logic        busy;

  // Buffer swap
  logic        swap_req;
  logic        swap_done;
  logic        front_sel;

  modport slave (
    input  pixel_x, pixel_y,
    input  wr_en, wr_x, wr_y, wr_data,
    input  clear_req, clear_color,
    input  swap_req,
    output out_r, out_g, out_b,
    output wr_ready, busy, swap_done, front_sel
  );

  modport master (
    output pixel_x, pixel_y,
    output wr_en, wr_x, wr_y, wr_data,
    output clear_req, clear_color,
    output swap_req,
    input  out_r, out_g, out_b,
    input  wr_ready, busy, swap_done, front_sel
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Framebuffer scan-out: a FB_W x FB_H RGB444 framebuffer shown scaled by
// 2**SCALE_SHIFT. Returns the colour for (pixel_x, pixel_y) exactly two
// cycles after the coordinates are presented. Game logic writes pixels into
// the back bank, fills it with a clear engine, and requests swaps that take
// effect only at the frame end (vertical blanking).
//
// Build option: define FB_DOUBLE_BUFFER_EN for two banks (front/back).
// Without it there is a single bank that is both front and back; swaps
// still handshake (swap_done pulses) but front_sel stays 0.

module framebuffer_scanout #(
  parameter int unsigned FB_W        = 200,
  parameter int unsigned FB_H        = 150,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  framebuffer_scanout_if.slave  bus
);

  localparam int unsigned FB_DEPTH = FB_W * FB_H;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned NUM_BANKS = 2;
`else
  localparam int unsigned NUM_BANKS = 1;
`endif
  localparam int unsigned MEM_DEPTH = NUM_BANKS * FB_DEPTH;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

  localparam logic [9:0]        COORD_NONE = 10'h3FF;
  localparam logic [9:0]        X_LIMIT    = 10'(FB_W << SCALE_SHIFT);
  localparam logic [9:0]        Y_LIMIT    = 10'(FB_H << SCALE_SHIFT);
  localparam logic [9:0]        Y_LAST     = Y_LIMIT - 10'd1;
  localparam logic [8:0]        WR_X_LIMIT = 9'(FB_W);
  localparam logic [8:0]        WR_Y_LIMIT = 9'(FB_H);
  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(FB_DEPTH - 1);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(FB_DEPTH);
`endif

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // What drives the colour output in the cycle after a RAM read slot.
  typedef enum logic [1:0] {
    OUT_RESET,
    OUT_BG,
    OUT_RAM
  } out_sel_t;

  // ---------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------
  // Read pipeline
  logic [9:0]        fb_x;
  logic [9:0]        fb_y;
  logic              rd_valid_d, rd_valid_q;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [ADDR_W-1:0] rd_mem_addr;
  out_sel_t          out_sel_d, out_sel_q;
  logic [11:0]       ram_rdata;
  logic [11:0]       out_rgb;

  // Write port and clear engine
  state_t            state_d, state_q;
  logic [ADDR_W-1:0] clr_addr_d, clr_addr_q;
  logic [11:0]       clr_color_d, clr_color_q;
  logic              mem_we;
  logic [ADDR_W-1:0] pix_waddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [11:0]       mem_wdata;

  // Frame end detection and swap
  logic [9:0]        prev_y_d, prev_y_q;
  logic              frame_end;
  logic              pending_d, pending_q;
  logic              swap_done_d, swap_done_q;
  logic              front_sel_d, front_sel_q;

  logic [11:0]       mem [MEM_DEPTH];

  // ---------------------------------------------------------------------
  // Stage 1: validate display coordinates and form the framebuffer index
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    fb_x       = bus.pixel_x >> SCALE_SHIFT;
    fb_y       = bus.pixel_y >> SCALE_SHIFT;
    rd_valid_d = (bus.pixel_x != COORD_NONE) && (bus.pixel_y != COORD_NONE) &&
                 (bus.pixel_x <  X_LIMIT)    && (bus.pixel_y <  Y_LIMIT);
    rd_addr_d  = ADDR_W'(fb_y) * ADDR_W'(FB_W) + ADDR_W'(fb_x);
    out_sel_d  = rd_valid_q ? OUT_RAM : OUT_BG;
  end

  // Front bank read address for the registered stage-1 index
  always_comb begin
`ifdef FB_DOUBLE_BUFFER_EN
    rd_mem_addr = front_sel_q ? (rd_addr_q + BANK_OFFSET) : rd_addr_q;
`else
    rd_mem_addr = rd_addr_q;
`endif
  end

  // Colour mux: RAM word, background, or black straight out of reset
  always_comb begin
    out_rgb = 12'h000;
    unique case (out_sel_q)
      OUT_RAM: out_rgb = ram_rdata;
      OUT_BG:  out_rgb = BG_COLOR;
      default: out_rgb = 12'h000;
    endcase
  end

  assign bus.out_r = out_rgb[11:8];
  assign bus.out_g = out_rgb[7:4];
  assign bus.out_b = out_rgb[3:0];

  // ---------------------------------------------------------------------
  // Write port and clear engine: one RAM write per cycle at most
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    mem_we      = 1'b0;
    pix_waddr   = '0;
    mem_wdata   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Out-of-range coordinates are dropped here, before the index is
        // formed, so they can never wrap onto a neighbouring row.
        if (bus.wr_en && ({1'b0, bus.wr_x} < WR_X_LIMIT) &&
            ({1'b0, bus.wr_y} < WR_Y_LIMIT)) begin
          mem_we    = 1'b1;
          pix_waddr = ADDR_W'(bus.wr_y) * ADDR_W'(FB_W) + ADDR_W'(bus.wr_x);
          mem_wdata = bus.wr_data;
        end
        if (bus.clear_req) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = bus.clear_color;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        pix_waddr = clr_addr_q;
        mem_wdata = clr_color_q;
        if (clr_addr_q == PIX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
    endcase
  end

  // Steer writes into the back bank, which is always the non-front one
  always_comb begin
`ifdef FB_DOUBLE_BUFFER_EN
    mem_waddr = front_sel_q ? pix_waddr : (pix_waddr + BANK_OFFSET);
`else
    mem_waddr = pix_waddr;
`endif
  end

  assign bus.wr_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------
  // Frame end detection and swap handshake
  // ---------------------------------------------------------------------
  always_comb begin
    prev_y_d    = bus.pixel_y;
    frame_end   = (bus.pixel_y == COORD_NONE) && (prev_y_q == Y_LAST);
    // A request arriving in the frame-end cycle itself is merged in here,
    // so it is honoured at that same event.
    pending_d   = pending_q | bus.swap_req;
    swap_done_d = 1'b0;
    front_sel_d = front_sel_q;
    if (frame_end && pending_d && (state_q == ST_IDLE)) begin
      pending_d   = 1'b0;
      swap_done_d = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
      front_sel_d = ~front_sel_q;
`endif
    end
  end

  assign bus.swap_done = swap_done_q;
  assign bus.front_sel = front_sel_q;

  // ---------------------------------------------------------------------
  // Control and pipeline registers, synchronous active-low reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flops, so every register
    // samples the pre-edge value of the others regardless of order.
    if (!reset_n) begin
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      out_sel_q   <= OUT_RESET;
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      prev_y_q    <= '0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      front_sel_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      out_sel_q   <= out_sel_d;
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      prev_y_q    <= prev_y_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      front_sel_q <= front_sel_d;
    end
  end

  // Framebuffer RAM: one write port, one registered read port
  always_ff @(posedge clk) begin
    // NOTE: the RAM array and its read register are deliberately left out
    // of reset so they map onto block RAM; the output mux masks the read
    // register until a real read has been issued.
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_valid_q) begin
      ram_rdata <= mem[rd_mem_addr];
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout. Colour reads are streamed
// from a table of {pixel_x, pixel_y, expected colour} records, one per
// cycle, so the two-cycle latency is checked on every vector. Swaps,
// clears and reset are driven by hand-written sequences. Expectations
// follow the build: FB_DOUBLE_BUFFER_EN selects the two-bank behaviour.

module tb_framebuffer_scanout;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam logic [9:0] NONE        = 10'h3FF;
  localparam int         CLEAR_CYCLES = 200 * 150;
  localparam int         WAIT_BUDGET  = 31000;

  logic clk = 1'b0;
  logic reset_n;

  framebuffer_scanout_if bus ();

  framebuffer_scanout dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] exp;
  } rd_vec_t;

  rd_vec_t vec [$];
  int      tests_run    = 0;
  int      tests_failed = 0;
  bit      exp_front    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rgb_now();
    return {bus.out_r, bus.out_g, bus.out_b};
  endfunction

  task automatic add(input int x, input int y, input logic [11:0] exp);
    rd_vec_t v;
    v.px  = 10'(x);
    v.py  = 10'(y);
    v.exp = exp;
    vec.push_back(v);
  endtask

  // Present one vector per cycle; vector j is checked two cycles later.
  task automatic run_table(input string name);
    int n;
    n = vec.size();
    for (int j = 0; j < n + 2; j++) begin
      @(negedge clk);
      if (j >= 2) check($sformatf("%s[%0d]", name, j - 2), 32'(rgb_now()), 32'(vec[j-2].exp));
      if (j < n) begin
        bus.pixel_x = vec[j].px;
        bus.pixel_y = vec[j].py;
      end else begin
        bus.pixel_x = NONE;
        bus.pixel_y = NONE;
      end
    end
    vec.delete();
  endtask

  task automatic write_px(input int x, input int y, input logic [11:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_x    = 8'(x);
    bus.wr_y    = 8'(y);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
  endtask

  // Leaves clear_req low one negedge after the accepting edge.
  task automatic pulse_clear(input logic [11:0] color);
    @(negedge clk);
    bus.clear_req   = 1'b1;
    bus.clear_color = color;
    @(negedge clk);
    bus.clear_req   = 1'b0;
  endtask

  // Last active line then blanking; counts swap_done pulses afterwards.
  task automatic frame_end(output int pulses);
    pulses = 0;
    @(negedge clk);
    bus.pixel_x = 10'd0;
    bus.pixel_y = 10'd599;
    @(negedge clk);
    bus.pixel_x = NONE;
    bus.pixel_y = NONE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.swap_done) pulses++;
    end
  endtask

  // Bounded wait for the clear engine to go idle.
  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    while (bus.busy && busy_cycles < WAIT_BUDGET) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int busy_cycles;
    int bad_ready;

    bus.pixel_x     = NONE;
    bus.pixel_y     = NONE;
    bus.wr_en       = 1'b0;
    bus.wr_x        = '0;
    bus.wr_y        = '0;
    bus.wr_data     = '0;
    bus.clear_req   = 1'b0;
    bus.clear_color = '0;
    bus.swap_req    = 1'b0;
    reset_n         = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out",       32'(rgb_now()),     32'h000);
    check("rst_wr_ready",  32'(bus.wr_ready),  32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_swap_done", 32'(bus.swap_done), 32'd0);
    check("rst_front_sel", 32'(bus.front_sel), 32'd0);
    reset_n = 1'b1;

    // Test 1/2: write, swap at frame end, latency, invalid coords, corner
    write_px(10, 20, 12'hF0A);
    write_px(199, 149, 12'h5A3);
    pulse_swap();
    @(negedge clk);
    check("t1_no_early_swap", 32'(bus.swap_done), 32'd0);
    frame_end(pulses);
    exp_front = exp_front ^ DB;
    check("t1_swap_pulses", 32'(pulses), 32'd1);
    check("t1_front_sel",   32'(bus.front_sel), 32'(exp_front));
    add(40,  80,  12'hF0A);
    add(43,  83,  12'hF0A);
    add(1023, 80, 12'h000);
    add(41,  82,  12'hF0A);
    add(800, 81,  12'h000);
    add(42,  81,  12'hF0A);
    add(799, 599, 12'h5A3);
    add(796, 596, 12'h5A3);
    add(40,  600, 12'h000);
    add(40,  1023, 12'h000);
    add(43,  80,  12'hF0A);
    run_table("t1_read");

    // Test 3: clear runs FB_W*FB_H cycles; a write during it is dropped
    pulse_clear(12'h00F);
    bus.wr_en   = 1'b1;
    bus.wr_x    = 8'd5;
    bus.wr_y    = 8'd5;
    bus.wr_data = 12'h777;
    check("t3_busy_start",  32'(bus.busy),     32'd1);
    check("t3_ready_start", 32'(bus.wr_ready), 32'd0);
    busy_cycles = 1;
    bad_ready   = 0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    while (bus.busy && busy_cycles < WAIT_BUDGET) begin
      busy_cycles++;
      if (bus.wr_ready) bad_ready++;
      @(negedge clk);
    end
    check("t3_busy_cycles", 32'(busy_cycles), 32'(CLEAR_CYCLES));
    check("t3_ready_low",   32'(bad_ready),   32'd0);
    check("t3_ready_after", 32'(bus.wr_ready), 32'd1);
    pulse_swap();
    frame_end(pulses);
    exp_front = exp_front ^ DB;
    check("t3_swap_pulses", 32'(pulses), 32'd1);
    check("t3_front_sel",   32'(bus.front_sel), 32'(exp_front));
    add(0,   0,   12'h00F);
    add(799, 599, 12'h00F);
    add(20,  20,  12'h00F);
    add(40,  80,  12'h00F);
    add(400, 300, 12'h00F);
    run_table("t3_read");

    // Test 4: swap requested mid-clear waits for a frame end with busy=0
    pulse_clear(12'h0F0);
    repeat (20) @(negedge clk);
    pulse_swap();
    repeat (20) @(negedge clk);
    frame_end(pulses);
    check("t4_no_swap_busy", 32'(pulses), 32'd0);
    check("t4_front_held",   32'(bus.front_sel), 32'(exp_front));
    check("t4_still_busy",   32'(bus.busy), 32'd1);
    wait_idle(busy_cycles);
    check("t4_clear_ends", 32'(bus.busy), 32'd0);
    frame_end(pulses);
    exp_front = exp_front ^ DB;
    check("t4_swap_pulses", 32'(pulses), 32'd1);
    check("t4_front_sel",   32'(bus.front_sel), 32'(exp_front));
    add(0,   0,   12'h0F0);
    add(797, 598, 12'h0F0);
    add(123, 45,  12'h0F0);
    run_table("t4_read");

    // Test 5: out-of-range write does not alias onto fb (0,6)
    write_px(0, 6, 12'h456);
    write_px(200, 5, 12'h123);
    pulse_swap();
    frame_end(pulses);
    exp_front = exp_front ^ DB;
    check("t5_swap_pulses", 32'(pulses), 32'd1);
    add(0,   24, 12'h456);
    add(3,   27, 12'h456);
    add(0,   20, DB ? 12'h00F : 12'h0F0);
    add(796, 20, DB ? 12'h00F : 12'h0F0);
    run_table("t5_read");

    // Test 5b: reset in the middle of a clear aborts it
    pulse_clear(12'hF00);
    repeat (50) @(negedge clk);
    check("t5_busy_mid", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy",      32'(bus.busy),      32'd0);
    check("t5_rst_wr_ready",  32'(bus.wr_ready),  32'd1);
    check("t5_rst_front_sel", 32'(bus.front_sel), 32'd0);
    check("t5_rst_out",       32'(rgb_now()),     32'h000);
    reset_n   = 1'b1;
    exp_front = 1'b0;

    // Test 6: single bank shows writes immediately; two banks after swap
    write_px(0, 0, 12'hFFF);
    add(0, 0, DB ? 12'h00F : 12'hFFF);
    add(3, 3, DB ? 12'h00F : 12'hFFF);
    run_table("t6_pre_swap");
    pulse_swap();
    frame_end(pulses);
    exp_front = exp_front ^ DB;
    check("t6_swap_pulses", 32'(pulses), 32'd1);
    check("t6_front_sel",   32'(bus.front_sel), 32'(exp_front));
    add(0, 0, 12'hFFF);
    add(2, 1, 12'hFFF);
    run_table("t6_post_swap");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
